// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light timing path: phase encoding,
// default per-phase tick counts and the light-to-phase decode.
package traffic_pkg;

    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned MAIN_TICKS_DEF = 20;
    localparam int unsigned SIDE_TICKS_DEF = 10;
    localparam int unsigned WARN_TICKS_DEF = 3;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_MAIN = 2'd1,
        PH_SIDE = 2'd2,
        PH_WARN = 2'd3
    } phase_t;

    // Warning outranks side, side outranks main, so overlapping greens time as SIDE.
    function automatic phase_t decode_phase(input logic main_green,
                                            input logic side_green,
                                            input logic warning);
        phase_t ph;
        ph = PH_IDLE;
        if (warning)         ph = PH_WARN;
        else if (side_green) ph = PH_SIDE;
        else if (main_green) ph = PH_MAIN;
        return ph;
    endfunction

endpackage

// File: rtl/ped_request_latch.sv
// Request latch for an asynchronous push-button or sensor: two-stage
// synchroniser, rising-edge detect and a set/clear latch where clear wins.
module ped_request_latch (
    input  logic clk,
    input  logic rst,
    input  logic button,
    input  logic clear,
    input  logic block,
    output logic request
);

    logic sync1;
    logic sync2;
    logic sync3;
    logic rise_c;

    assign rise_c = sync2 & ~sync3;

    // A held button yields one rising edge, hence one request per press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            request <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            sync3 <= sync2;
            if (clear)
                request <= 1'b0;
            else if (rise_c && !block)
                request <= 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic-light controller: times each light phase,
// raises timer_done on expiry and latches pedestrian requests.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned MAIN_TICKS = MAIN_TICKS_DEF,
    parameter int unsigned SIDE_TICKS = SIDE_TICKS_DEF,
    parameter int unsigned WARN_TICKS = WARN_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             main_green,
    input  logic             side_green,
    input  logic             warning,
    input  logic             ped_button,
    output logic             timer_done,
    output logic             pedestrian_request,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             conflict
);

    phase_t           phase_d_c;
    phase_t           phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] dur_c;
    logic             phase_chg_c;
    logic             side_entry_c;
    logic             in_side_c;

    always_comb begin
        phase_d_c    = decode_phase(main_green, side_green, warning);
        phase_chg_c  = (phase_d_c != phase_q);
        in_side_c    = (phase_q == PH_SIDE);
        side_entry_c = phase_chg_c && (phase_d_c == PH_SIDE);
        dur_c        = '0;
        case (phase_d_c)
            PH_MAIN: dur_c = CNT_W'(MAIN_TICKS);
            PH_SIDE: dur_c = CNT_W'(SIDE_TICKS);
            PH_WARN: dur_c = CNT_W'(WARN_TICKS);
            default: dur_c = '0;
        endcase
    end

    // A phase change reloads and drops timer_done in one edge, swallowing any tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q    <= PH_IDLE;
            cnt_q      <= '0;
            timer_done <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            if (main_green && side_green)
                conflict <= 1'b1;
            if (phase_chg_c) begin
                phase_q    <= phase_d_c;
                cnt_q      <= dur_c;
                timer_done <= 1'b0;
            end else if (tick && (cnt_q != '0)) begin
                cnt_q      <= cnt_q - CNT_W'(1);
                timer_done <= (cnt_q == CNT_W'(1));
            end else begin
                timer_done <= (cnt_q == '0) && (phase_q != PH_IDLE);
            end
        end
    end

    // Request is served by the side phase: cleared on entry, deaf while in it.
    ped_request_latch u_ped (
        .clk     (clk),
        .rst     (rst),
        .button  (ped_button),
        .clear   (side_entry_c),
        .block   (in_side_c),
        .request (pedestrian_request)
    );

    assign phase     = phase_q;
    assign remaining = cnt_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Randomised bench for traffic_phase_timer against a cycle-level reference
// model built from the phase, timing and pedestrian rules.
module tb_traffic_phase_timer;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned MAIN_TICKS = 20;
    localparam int unsigned SIDE_TICKS = 10;
    localparam int unsigned WARN_TICKS = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             main_green;
    logic             side_green;
    logic             warning;
    logic             ped_button;
    logic             timer_done;
    logic             pedestrian_request;
    logic [1:0]       phase;
    logic [CNT_W-1:0] remaining;
    logic             conflict;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: phase number, ticks left, request, conflict, button history.
    int m_phase, m_rem, m_req, m_conf;
    int h1, h2, h3;

    traffic_phase_timer #(
        .CNT_W      (CNT_W),
        .MAIN_TICKS (MAIN_TICKS),
        .SIDE_TICKS (SIDE_TICKS),
        .WARN_TICKS (WARN_TICKS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tick               (tick),
        .main_green         (main_green),
        .side_green         (side_green),
        .warning            (warning),
        .ped_button         (ped_button),
        .timer_done         (timer_done),
        .pedestrian_request (pedestrian_request),
        .phase              (phase),
        .remaining          (remaining),
        .conflict           (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int decode(input logic m, input logic s, input logic w);
        if (w) return 3;
        if (s) return 2;
        if (m) return 1;
        return 0;
    endfunction

    function automatic int duration(input int p);
        case (p)
            1: return int'(MAIN_TICKS);
            2: return int'(SIDE_TICKS);
            3: return int'(WARN_TICKS);
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_req = 0; m_conf = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    // One clock edge of the reference behaviour; h1..h3 are button samples of the previous three edges.
    task automatic model_edge();
        int  nd;
        bit  rise;
        if (!rst) begin
            model_reset();
            return;
        end
        nd   = decode(main_green, side_green, warning);
        rise = (h2 != 0) && (h3 == 0);
        if (nd == 2 && m_phase != 2)      m_req = 0;
        else if (rise && m_phase != 2)    m_req = 1;
        h3 = h2; h2 = h1; h1 = int'(ped_button);
        if (main_green && side_green) m_conf = 1;
        if (nd != m_phase) begin
            m_phase = nd;
            m_rem   = duration(nd);
        end else if (tick && m_rem > 0) begin
            m_rem--;
        end
    endtask

    task automatic check_all();
        check("phase",     int'(phase),              m_phase);
        check("remaining", int'(remaining),          m_rem);
        check("timer_done",int'(timer_done),         (m_phase != 0 && m_rem == 0) ? 1 : 0);
        check("ped_req",   int'(pedestrian_request), m_req);
        check("conflict",  int'(conflict),           m_conf);
    endtask

    // Advance one edge, update the model, compare just after the edge, return at the next negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic drive(input logic m, input logic s, input logic w,
                         input logic t, input logic p);
        main_green = m; side_green = s; warning = w; tick = t; ped_button = p;
        step();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        check_all();
        check("rst_async_done", int'(timer_done), 0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        int rem_seen;
        rst = 1'b0; tick = 1'b1; main_green = 1'b0; side_green = 1'b0;
        warning = 1'b0; ped_button = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        step();
        rst = 1'b1;

        // Main phase with per-cycle ticks: done exactly MAIN_TICKS edges after the change edge.
        repeat (MAIN_TICKS) drive(1, 0, 0, 1, 0);
        check("main_pre_done", int'(timer_done), 0);
        drive(1, 0, 0, 1, 0);
        check("main_done", int'(timer_done), 1);

        // Reset mid-count with main still asserted.
        drive(0, 0, 0, 1, 0);
        repeat (5) drive(1, 0, 0, 1, 0);
        do_reset();
        drive(1, 0, 0, 1, 0);
        check("after_rst_rem", int'(remaining), int'(MAIN_TICKS));

        // Warning with a gated time base, held past expiry, then back to main.
        for (int i = 0; i < 24; i++) drive(1, 0, 1, (i % 4) == 3, 0);
        check("warn_hold", int'(timer_done), 1);
        drive(1, 0, 0, 1, 0);
        check("warn_to_main_done", int'(timer_done), 0);
        check("warn_to_main_rem", int'(remaining), int'(MAIN_TICKS));

        // Early change to side at remaining 5; a held button during main gives one request.
        rem_seen = 0;
        for (int i = 0; i < 40 && int'(remaining) != 5; i++)
            drive(1, 0, 0, 1, i >= 2 && i < 12);
        check("reach_rem5", int'(remaining), 5);
        drive(1, 1, 0, 1, 0);
        check("early_side_phase", int'(phase), 2);
        check("early_side_rem", int'(remaining), int'(SIDE_TICKS));
        check("early_side_req", int'(pedestrian_request), 0);

        // Press during side, then a press whose edge lands on the side-entry edge.
        repeat (4) drive(1, 1, 0, 1, 1);
        repeat (4) drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 1);
        drive(0, 1, 0, 1, 1);
        check("entry_press_req", int'(pedestrian_request), 0);
        repeat (4) drive(0, 1, 0, 1, 0);

        // Idle holds timer_done low indefinitely.
        repeat (30) drive(0, 0, 0, 1, 0);
        check("idle_done", int'(timer_done), 0);
        check("conflict_sticky", int'(conflict), 1);
        do_reset();

        // Random segments of light patterns, tick rates and button activity.
        for (int seg = 0; seg < 160; seg++) begin
            logic m, s, w, p;
            int   len, tmode;
            m = 1'($urandom_range(0, 3) != 0);
            s = 1'($urandom_range(0, 2) == 0);
            w = 1'($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin m = 1'b1; s = 1'b1; end
            if ($urandom_range(0, 7) == 0) begin m = 1'b0; s = 1'b0; w = 1'b0; end
            len   = int'($urandom_range(1, 30));
            tmode = int'($urandom_range(0, 2));
            p     = ped_button;
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 7) == 0) p = ~p;
                drive(m, s, w, (tmode == 0) ? 1'b1 : 1'($urandom_range(0, tmode) == 0), p);
            end
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
- Companion to the traffic-light controller FSM, on the opposite side of its interface.
- Consumes the controller's light outputs (main_green, side_green, warning) and produces the two controller inputs: timer_done and pedestrian_request.
- Times each light phase against per-phase durations.
- Synchronises and latches the raw pedestrian push-button until the side phase serves it.

Parameters:
- CNT_W, 8, counter width in bits.
- MAIN_TICKS, 20, main-green phase length in ticks (1..2^CNT_W-1).
- SIDE_TICKS, 10, side-green phase length in ticks (1..2^CNT_W-1).
- WARN_TICKS, 3, warning phase length in ticks (1..2^CNT_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle time-base strobe from the prescaler; tie to 1 for per-cycle timing.
- main_green  in  1  from controller.
- side_green  in  1  from controller.
- warning  in  1  from controller.
- ped_button  in  1  raw asynchronous push-button.
- timer_done  out  1  current phase has expired; level.
- pedestrian_request  out  1  latched pending pedestrian request; level.
- phase  out  2  timed phase: 0 IDLE, 1 MAIN, 2 SIDE, 3 WARN.
- remaining  out  CNT_W  ticks left in the current phase.
- conflict  out  1  sticky: main_green and side_green were seen high together.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; phase=IDLE; counter=0; synchroniser and edge registers=0.
- Phase decode (combinational, priority order):
  - warning=1 gives WARN;
  - else side_green=1 gives SIDE;
  - else main_green=1 gives MAIN;
  - else IDLE.
- State register phase_q; states IDLE/MAIN/SIDE/WARN. Transitions follow the decoded phase only, with no other conditions.
- Priority per clock edge:
  - Phase change (decoded != phase_q):
    - phase_q takes the decoded phase;
    - counter loads the duration (MAIN_TICKS/SIDE_TICKS/WARN_TICKS, or 0 for IDLE);
    - timer_done <= 0.
    - A tick in the same cycle is ignored.
  - Else tick=1 and counter!=0: counter decrements; timer_done <= (counter==1).
  - Else: timer_done <= (counter==0 && phase_q!=IDLE).
- Resulting timing:
  - With tick tied to 1 and duration N, timer_done rises N cycles after the phase-change edge.
  - timer_done holds high until the next phase change; it is never high in IDLE.
  - The phase-change edge deasserts timer_done in the same edge as the reload, with no stale pulse into the new phase.
- remaining = counter; phase = phase_q; both registered.
- Pedestrian path:
  - ped_button passes through a 2-FF synchroniser, then rising-edge detection (sync2 & ~sync3).
  - pedestrian_request is a set/clear latch:
    - set on a detected edge;
    - cleared on the edge where phase_q enters SIDE.
  - Clear wins over set in the same cycle.
  - Edges detected while phase_q==SIDE are ignored, because the request is already being served.
  - Held button produces a single request; a new press is needed after release.
  - Latency: a button rising between edges k-1 and k yields pedestrian_request=1 after edge k+2.
- conflict:
  - set when main_green & side_green both =1 at an edge;
  - cleared only by reset;
  - the phase decode still applies priority (SIDE).
- Reset mid-phase: immediate return to reset values; the pending pedestrian request is lost.

Decomposition:
- Shared package traffic_pkg:
  - phase encoding constants (PH_IDLE, PH_MAIN, PH_SIDE, PH_WARN);
  - default tick counts.
- One natural sub-module: ped_request_latch (synchroniser + edge detect + set/clear latch). It is reusable for side-street vehicle sensors.

Test Plan:
- Reset: rst=0 mid-count with main_green=1 -> all outputs 0 within the same cycle; after release, main_green=1 with tick=1 gives phase=1, remaining=MAIN_TICKS, and timer_done=1 exactly MAIN_TICKS cycles after the phase edge.
- Hold and gated ticks: WARN_TICKS=3, tick asserted every 4th cycle, warning=1 -> timer_done rises after the 3rd tick and stays 1 until warning drops to the main phase; then it goes to 0 on that edge and remaining=MAIN_TICKS.
- Early phase change: at remaining=5 in MAIN, the controller raises side_green -> phase=2, remaining=SIDE_TICKS, timer_done stays 0.
- Pedestrian latency and single request: ped_button pulse held 10 cycles during MAIN -> pedestrian_request=1 three edges later; exactly one request; it stays 1 until the SIDE entry edge, then 0.
- Pedestrian during SIDE: a press during SIDE leaves pedestrian_request=0; a press in the entry cycle of SIDE also leaves it 0 (clear wins).
- Conflict and IDLE: main_green=side_green=1 -> conflict=1 (sticky), phase=2; all inputs 0 -> phase=0, timer_done=0 indefinitely.
